// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul: sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// A start/busy/done handshake drives a three-state FSM (IDLE, CALC, FIN).
// One adder is reused for WIDTH iterations, so a result takes WIDTH clocks.
// Optional macro SIGNED_MUL_EN: treat a, b and p as two's complement.
//   Operand magnitudes go through the unsigned core.
//   The product sign is re-applied on the completion edge.
//   Leave the macro undefined for the plain unsigned build.
// Handshake:
//   start is sampled only while busy is low, i.e. in IDLE or FIN.
//   A request seen in FIN is taken back to back with the one that just finished.
//   done is a one-cycle pulse. p is valid from that cycle and holds until
//   the next completion.
module seq_shift_add_mul #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state_q;
    // The lower half of the accumulator doubles as the multiplier shift register.
    // acc_q[0] is therefore the multiplier bit for the current iteration.
    // Bits are shifted out as product bits are shifted in.
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   p_q;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   p_d;
    logic                 last_iter;

`ifdef SIGNED_MUL_EN
    logic                 sign_q;
    logic                 sign_d;

    // Operand magnitudes: -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        a_mag  = a[WIDTH-1] ? (~a + 1'b1) : a;
        b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;
        sign_d = a[WIDTH-1] ^ b[WIDTH-1];
    end
`else
    // Unsigned build: operands go straight into the core.
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    // One iteration: conditional add into the upper WIDTH+1 bits, then shift right by one.
    always_comb begin
        addend    = acc_q[0] ? mcand_q : {WIDTH{1'b0}};
        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_d     = {sum, acc_q[WIDTH-1:1]};
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef SIGNED_MUL_EN
        p_d       = sign_q ? (~acc_d + 1'b1) : acc_d;
`else
        p_d       = acc_d;
`endif
    end

    // Control FSM and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
`ifdef SIGNED_MUL_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, FIN: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q   <= {{WIDTH{1'b0}}, b_mag};
                        mcand_q <= a_mag;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
`ifdef SIGNED_MUL_EN
                        sign_q  <= sign_d;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        p_q     <= p_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= FIN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Bench for seq_shift_add_mul. It runs a WIDTH=8 and a WIDTH=3 instance side by side.
// A cycle-level reference model checks both instances on every falling edge.
// Directed sequences carry hand-computed literal expectations.
module tb_seq_shift_add_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s8 = 1'b0;
  logic        s3 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [2:0]  a3 = '0;
  logic [2:0]  b3 = '0;
  logic        busy8, done8, busy3, done3;
  logic [15:0] p8;
  logic [5:0]  p3;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  seq_shift_add_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  seq_shift_add_mul #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(s3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .p(p3)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else pass_cnt++;
  endtask

  // Product of w-bit operands, truncated to 2w bits (sign-aware when the signed build is on).
  function automatic logic [63:0] ref_mul(input int w, input logic [63:0] x, input logic [63:0] y);
    longint sx, sy, pr;
    sx = longint'(x & ((64'd1 << w) - 1));
    sy = longint'(y & ((64'd1 << w) - 1));
`ifdef SIGNED_MUL_EN
    if (sx[w-1]) sx = sx - (longint'(1) << w);
    if (sy[w-1]) sy = sy - (longint'(1) << w);
`endif
    pr = sx * sy;
    return 64'(pr) & ((64'd1 << (2 * w)) - 1);
  endfunction

  // reference model: an accepted request finishes WIDTH edges later
  logic        m_busy [2];
  logic        m_done [2];
  int          m_cnt  [2];
  logic [63:0] m_p    [2];
  logic [63:0] m_pend [2];
  logic        st_v   [2];
  logic [63:0] a_v    [2];
  logic [63:0] b_v    [2];
  int          w_v    [2];

  assign st_v[0] = s8;
  assign st_v[1] = s3;
  assign a_v[0]  = {56'b0, a8};
  assign a_v[1]  = {61'b0, a3};
  assign b_v[0]  = {56'b0, b8};
  assign b_v[1]  = {61'b0, b3};
  assign w_v[0]  = 8;
  assign w_v[1]  = 3;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_cnt[i]  <= 0;
        m_p[i]    <= '0;
        m_pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_busy[i]) begin
          if (m_cnt[i] == 1) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
            m_p[i]    <= m_pend[i];
          end
          m_cnt[i] <= m_cnt[i] - 1;
        end else begin
          m_done[i] <= 1'b0;
          if (st_v[i]) begin
            m_pend[i] <= ref_mul(w_v[i], a_v[i], b_v[i]);
            m_busy[i] <= 1'b1;
            m_cnt[i]  <= w_v[i];
          end
        end
      end
    end
  end

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    chk("busy8", {63'b0, busy8}, {63'b0, m_busy[0]});
    chk("done8", {63'b0, done8}, {63'b0, m_done[0]});
    chk("p8",    {48'b0, p8},    m_p[0]);
    chk("busy3", {63'b0, busy3}, {63'b0, m_busy[1]});
    chk("done3", {63'b0, done3}, {63'b0, m_done[1]});
    chk("p3",    {58'b0, p3},    m_p[1]);
  end

  // driver tasks
  task automatic go8(input logic [7:0] x, input logic [7:0] y);
    s8 = 1'b1; a8 = x; b8 = y;
    @(negedge clk);
    s8 = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int lim);
    int n;
    n = 0;
    while (!(idx == 0 ? done8 : done3) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) chk(idx == 0 ? "done8_timeout" : "done3_timeout",
                      {63'b0, (idx == 0 ? done8 : done3)}, 64'd1);
  endtask

  logic [15:0] sv_a [3];
  logic [15:0] sv_b [3];
  logic [15:0] sv_e [3];

  initial begin
    int n;
    int busy_n;
    int dn;

    // reset
    repeat (2) @(negedge clk);
    chk("reset_p8", {48'b0, p8}, 64'd0);
    chk("reset_busy8", {63'b0, busy8}, 64'd0);
    chk("reset_done8", {63'b0, done8}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 255 x 255: busy for 8 cycles, single done pulse
    go8(8'd255, 8'd255);
    busy_n = 0; n = 0;
    while (!done8 && n < 20) begin
      if (busy8) busy_n++;
      @(negedge clk);
      n++;
    end
    chk("t1_busy_cycles", 64'(busy_n), 64'd8);
    chk("t1_latency", 64'(n), 64'd8);
`ifdef SIGNED_MUL_EN
    chk("t1_p", {48'b0, p8}, 64'h0001);
`else
    chk("t1_p", {48'b0, p8}, 64'hFE01);
`endif
    @(negedge clk);
    chk("t1_done_pulse", {63'b0, done8}, 64'd0);

    // WIDTH=3 exhaustive sweep
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        s3 = 1'b1; a3 = 3'(i); b3 = 3'(j);
        @(negedge clk);
        s3 = 1'b0;
        wait_done(1, 10);
        chk("t2_p3", {58'b0, p3}, ref_mul(3, 64'(i), 64'(j)));
        if (i == 7 && j == 7) begin
`ifdef SIGNED_MUL_EN
          chk("t2_7x7", {58'b0, p3}, 64'h01);
`else
          chk("t2_7x7", {58'b0, p3}, 64'h31);
`endif
        end
        @(negedge clk);
      end
    end

    // zero multiplier, start pulsed during CALC must be ignored
    go8(8'h5A, 8'h00);
    repeat (2) @(negedge clk);
    s8 = 1'b1; a8 = 8'd3; b8 = 8'd3;
    @(negedge clk);
    s8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      if (done8) begin
        dn++;
        chk("t3_p_zero", {48'b0, p8}, 64'd0);
      end
      @(negedge clk);
    end
    chk("t3_done_count", 64'(dn), 64'd1);

    // back-to-back: start held high, second op taken in FIN
    s8 = 1'b1; a8 = 8'd3; b8 = 8'd4;
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd20;
    wait_done(0, 20);
    chk("t4_p_first", {48'b0, p8}, 64'd12);
    @(negedge clk);
    chk("t4_b2b_busy", {63'b0, busy8}, 64'd1);
    s8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_latency", 64'(n), 64'd8);
    chk("t4_p_second", {48'b0, p8}, 64'd200);
    @(negedge clk);

    // asynchronous reset between edges 4 and 5
    go8(8'd100, 8'd7);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", {63'b0, busy8}, 64'd0);
    chk("t5_rst_done", {63'b0, done8}, 64'd0);
    chk("t5_rst_p", {48'b0, p8}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    go8(8'd9, 8'd9);
    wait_done(0, 20);
    chk("t5_p_81", {48'b0, p8}, 64'd81);
    @(negedge clk);

    // sign-boundary operands
    sv_a[0] = 16'hFD; sv_b[0] = 16'h05;
    sv_a[1] = 16'h80; sv_b[1] = 16'h80;
    sv_a[2] = 16'h7F; sv_b[2] = 16'hFF;
`ifdef SIGNED_MUL_EN
    sv_e[0] = 16'hFFF1; sv_e[1] = 16'h4000; sv_e[2] = 16'hFF81;
`else
    sv_e[0] = 16'h04F1; sv_e[1] = 16'h4000; sv_e[2] = 16'h7E81;
`endif
    for (int k = 0; k < 3; k++) begin
      go8(sv_a[k][7:0], sv_b[k][7:0]);
      wait_done(0, 20);
      chk("t6_p", {48'b0, p8}, {48'b0, sv_e[k]});
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
